branch_resolver: RTL and testbench

- Decode-side counterpart of the fetch-stage predictor.
- Holds one prediction record per fetched instruction in an in-order queue. Pops a record when that instruction resolves and compares predicted against actual outcome.
- Drives the predictor training bus (is_branch/is_jump/is_taken/pht_index/inst_pc/target) and the fetch redirect (flush/exc_pc) back to PC.

---
 rtl/branch_resolver_if.sv | 52 +++++
 rtl/branch_resolver.sv | 131 +++++++++++++
 tb/tb_branch_resolver.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_resolver_if.sv
// Fetch/decode-to-resolver bundle: prediction records in, resolutions in, training and redirect out.
// master = fetch/decode side, slave = branch_resolver.
interface branch_resolver_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int GHR_WIDTH  = 8
);
    logic                  pred_valid;
    logic [ADDR_WIDTH-1:0] pred_pc;
    logic                  pred_taken;
    logic [GHR_WIDTH-1:0]  pred_pht_index;
    logic [ADDR_WIDTH-1:0] pred_target;
    logic                  pred_ready;

    logic                  res_valid;
    logic                  res_ready;
    logic [ADDR_WIDTH-1:0] res_pc;
    logic                  res_is_branch;
    logic                  res_is_jump;
    logic                  res_taken;
    logic [ADDR_WIDTH-1:0] res_target;

    logic                  exc_flush;
    logic [ADDR_WIDTH-1:0] exc_pc_in;

    logic                  is_branch_out;
    logic                  is_jump_out;
    logic                  is_taken_out;
    logic [GHR_WIDTH-1:0]  pht_index_out;
    logic [ADDR_WIDTH-1:0] inst_pc_out;
    logic [ADDR_WIDTH-1:0] target_out;
    logic                  flush_out;
    logic [ADDR_WIDTH-1:0] exc_pc_out;
    logic                  mispredict_out;

    modport master (
        output pred_valid, pred_pc, pred_taken, pred_pht_index, pred_target,
        output res_valid, res_pc, res_is_branch, res_is_jump, res_taken, res_target,
        output exc_flush, exc_pc_in,
        input  pred_ready, res_ready,
        input  is_branch_out, is_jump_out, is_taken_out, pht_index_out,
        input  inst_pc_out, target_out, flush_out, exc_pc_out, mispredict_out
    );

    modport slave (
        input  pred_valid, pred_pc, pred_taken, pred_pht_index, pred_target,
        input  res_valid, res_pc, res_is_branch, res_is_jump, res_taken, res_target,
        input  exc_flush, exc_pc_in,
        output pred_ready, res_ready,
        output is_branch_out, is_jump_out, is_taken_out, pht_index_out,
        output inst_pc_out, target_out, flush_out, exc_pc_out, mispredict_out
    );
endinterface

// File: rtl/branch_resolver.sv
// In-order prediction queue checked against decode resolutions; outputs one cycle after pop.
// pred_ready registered (count<DEPTH); res_ready only in RUN with a queued record. Optional BRANCH_STAT_EN adds counters.
module branch_resolver #(
    parameter int ADDR_WIDTH = 32,
    parameter int GHR_WIDTH  = 8,
    parameter int DEPTH      = 4
) (
    input  logic clk,
    input  logic rst,
    branch_resolver_if.slave bus
`ifdef BRANCH_STAT_EN
    ,
    output logic [31:0] stat_branch_cnt,
    output logic [31:0] stat_mispred_cnt
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {RUN, REDIRECT} state_t;

    logic [ADDR_WIDTH-1:0] q_pc     [DEPTH];
    logic [ADDR_WIDTH-1:0] q_target [DEPTH];
    logic [GHR_WIDTH-1:0]  q_idx    [DEPTH];
    logic                  q_taken  [DEPTH];

    logic [PW-1:0] head, tail;
    logic [CW-1:0] count;
    state_t        state;
    logic          pred_ready_q;

    logic                  push, pop;
    logic                  desync, mispred, train, keep;
    logic [ADDR_WIDTH-1:0] redirect_pc;
    logic [CW-1:0]         cnt_next;

    assign bus.pred_ready = pred_ready_q;
    assign bus.res_ready  = (state == RUN) && (count != '0);

    always_comb begin
        push        = bus.pred_valid && pred_ready_q && (state == RUN) && !bus.exc_flush;
        pop         = bus.res_valid && bus.res_ready && !bus.exc_flush;
        desync      = bus.res_pc != q_pc[head];
        mispred     = desync
                   || (bus.res_is_branch && (q_taken[head] != bus.res_taken))
                   || (bus.res_taken && (q_target[head] != bus.res_target))
                   || (!bus.res_is_branch && q_taken[head]);
        redirect_pc = bus.res_is_branch
                    ? (bus.res_taken ? bus.res_target : bus.res_pc + ADDR_WIDTH'(8))
                    : bus.res_pc + ADDR_WIDTH'(4);
        train       = pop && bus.res_is_branch && !desync;
        // Only a resolved branch keeps its delay slot; it may be arriving this very cycle.
        keep        = bus.res_is_branch && !desync && ((count > CW'(1)) || push);
        cnt_next    = count + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[tail]     <= bus.pred_pc;
            q_taken[tail]  <= bus.pred_taken;
            q_idx[tail]    <= bus.pred_pht_index;
            q_target[tail] <= bus.pred_target;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head               <= '0;
            tail               <= '0;
            count              <= '0;
            state              <= RUN;
            pred_ready_q       <= 1'b1;
            bus.is_branch_out  <= 1'b0;
            bus.is_jump_out    <= 1'b0;
            bus.is_taken_out   <= 1'b0;
            bus.pht_index_out  <= '0;
            bus.inst_pc_out    <= '0;
            bus.target_out     <= '0;
            bus.flush_out      <= 1'b0;
            bus.exc_pc_out     <= '0;
            bus.mispredict_out <= 1'b0;
        end else begin
            bus.is_branch_out  <= train;
            bus.is_jump_out    <= train && bus.res_is_jump;
            bus.is_taken_out   <= train && bus.res_taken;
            bus.pht_index_out  <= train ? q_idx[head] : '0;
            bus.inst_pc_out    <= train ? bus.res_pc : '0;
            bus.target_out     <= train ? bus.res_target : '0;
            bus.flush_out      <= pop && mispred;
            bus.exc_pc_out     <= (pop && mispred) ? redirect_pc : '0;
            bus.mispredict_out <= pop && mispred;

            if (bus.exc_flush) begin
                // Exception wins over everything: no training, queue dropped.
                bus.flush_out  <= 1'b1;
                bus.exc_pc_out <= bus.exc_pc_in;
                head           <= '0;
                tail           <= '0;
                count          <= '0;
                state          <= RUN;
                pred_ready_q   <= 1'b1;
            end else if (pop && mispred) begin
                head         <= head + PW'(1);
                tail         <= head + PW'(1) + PW'(keep);
                count        <= CW'(keep);
                state        <= REDIRECT;
                pred_ready_q <= 1'b1;
            end else begin
                head         <= head + PW'(pop);
                tail         <= tail + PW'(push);
                count        <= cnt_next;
                state        <= RUN;
                pred_ready_q <= cnt_next < CW'(DEPTH);
            end
        end
    end

`ifdef BRANCH_STAT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_branch_cnt  <= '0;
            stat_mispred_cnt <= '0;
        end else begin
            if (bus.is_branch_out && (stat_branch_cnt != '1))
                stat_branch_cnt <= stat_branch_cnt + 32'd1;
            if (bus.mispredict_out && (stat_mispred_cnt != '1))
                stat_mispred_cnt <= stat_mispred_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_branch_resolver.sv
// Bench for branch_resolver: vector table plus hand sequences, outputs checked through an expectation queue.
module tb_branch_resolver;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    branch_resolver_if #(.ADDR_WIDTH(32), .GHR_WIDTH(8)) bus ();

`ifdef BRANCH_STAT_EN
    logic [31:0] stat_b, stat_m;
    branch_resolver #(.ADDR_WIDTH(32), .GHR_WIDTH(8), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .bus(bus), .stat_branch_cnt(stat_b), .stat_mispred_cnt(stat_m));
`else
    branch_resolver #(.ADDR_WIDTH(32), .GHR_WIDTH(8), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .bus(bus));
`endif

    typedef struct packed {
        logic        flush;
        logic        mis;
        logic [31:0] epc;
        logic        br;
        logic        jmp;
        logic        tk;
        logic [7:0]  idx;
        logic [31:0] ipc;
        logic [31:0] tgt;
    } exp_t;

    typedef struct packed {
        logic [31:0] p_pc;
        logic        p_tk;
        logic [7:0]  p_idx;
        logic [31:0] p_tgt;
        logic        two;
        logic [31:0] r_pc;
        logic        r_br;
        logic        r_jmp;
        logic        r_tk;
        logic [31:0] r_tgt;
        exp_t        e;
        logic        rdy1;
        logic        rdy2;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic exp_t actual();
        exp_t a;
        a.flush = bus.flush_out;
        a.mis   = bus.mispredict_out;
        a.epc   = bus.exc_pc_out;
        a.br    = bus.is_branch_out;
        a.jmp   = bus.is_jump_out;
        a.tk    = bus.is_taken_out;
        a.idx   = bus.pht_index_out;
        a.ipc   = bus.inst_pc_out;
        a.tgt   = bus.target_out;
        return a;
    endfunction

    function automatic exp_t mk_exp(input logic flush, input logic mis, input logic [31:0] epc,
                                    input logic br, input logic jmp, input logic tk,
                                    input logic [7:0] idx, input logic [31:0] ipc, input logic [31:0] tgt);
        exp_t e;
        e = '{flush, mis, epc, br, jmp, tk, idx, ipc, tgt};
        return e;
    endfunction

    function automatic vec_t mk(input logic [31:0] p_pc, input logic p_tk, input logic [7:0] p_idx,
                                input logic [31:0] p_tgt, input logic two, input logic [31:0] r_pc,
                                input logic r_br, input logic r_jmp, input logic r_tk,
                                input logic [31:0] r_tgt, input exp_t e, input logic rdy1, input logic rdy2);
        vec_t v;
        v = '{p_pc, p_tk, p_idx, p_tgt, two, r_pc, r_br, r_jmp, r_tk, r_tgt, e, rdy1, rdy2};
        return v;
    endfunction

    // Every cycle: compare registered outputs with the queued expectation, or with all-zero when none is due.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (rst) begin
            e = '0;
            if (exp_q.size() > 0) e = exp_q.pop_front();
            check("outputs", actual(), e);
        end
    end

    task automatic clear();
        bus.pred_valid = 0; bus.pred_pc = 0; bus.pred_taken = 0; bus.pred_pht_index = 0; bus.pred_target = 0;
        bus.res_valid = 0; bus.res_pc = 0; bus.res_is_branch = 0; bus.res_is_jump = 0; bus.res_taken = 0;
        bus.res_target = 0; bus.exc_flush = 0; bus.exc_pc_in = 0;
    endtask

    task automatic set_push(input logic [31:0] pc, input logic tk, input logic [7:0] idx, input logic [31:0] tgt);
        bus.pred_valid = 1; bus.pred_pc = pc; bus.pred_taken = tk; bus.pred_pht_index = idx; bus.pred_target = tgt;
    endtask

    task automatic set_res(input logic [31:0] pc, input logic br, input logic jmp, input logic tk, input logic [31:0] tgt);
        bus.res_valid = 1; bus.res_pc = pc; bus.res_is_branch = br; bus.res_is_jump = jmp;
        bus.res_taken = tk; bus.res_target = tgt;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear();
        rst = 0;
        @(negedge clk);
        rst = 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin
        clear();
        // correct taken branch
        vecs.push_back(mk(32'h100, 1, 8'h3A, 32'h200, 0, 32'h100, 1, 0, 1, 32'h200,
            mk_exp(0, 0, 0, 1, 0, 1, 8'h3A, 32'h100, 32'h200), 0, 0));
        // predicted not taken, actually taken: delay slot kept
        vecs.push_back(mk(32'h100, 0, 8'h11, 32'h0, 1, 32'h100, 1, 0, 1, 32'h300,
            mk_exp(1, 1, 32'h300, 1, 0, 1, 8'h11, 32'h100, 32'h300), 0, 1));
        // predicted taken, actually not taken
        vecs.push_back(mk(32'h100, 1, 8'h22, 32'h200, 0, 32'h100, 1, 0, 0, 32'h200,
            mk_exp(1, 1, 32'h108, 1, 0, 0, 8'h22, 32'h100, 32'h200), 0, 0));
        // non-branch false hit empties queue
        vecs.push_back(mk(32'h120, 1, 8'h05, 32'h180, 1, 32'h120, 0, 0, 0, 32'h0,
            mk_exp(1, 1, 32'h124, 0, 0, 0, 8'h00, 32'h0, 32'h0), 0, 0));
        // correct jump
        vecs.push_back(mk(32'h200, 1, 8'h44, 32'h400, 1, 32'h200, 1, 1, 1, 32'h400,
            mk_exp(0, 0, 0, 1, 1, 1, 8'h44, 32'h200, 32'h400), 1, 1));
        // right direction, wrong target
        vecs.push_back(mk(32'h300, 1, 8'h55, 32'h500, 0, 32'h300, 1, 0, 1, 32'h600,
            mk_exp(1, 1, 32'h600, 1, 0, 1, 8'h55, 32'h300, 32'h600), 0, 0));
        // fall-through redirect wraps past the top of the address space
        vecs.push_back(mk(32'hFFFF_FFFC, 1, 8'h01, 32'h10, 0, 32'hFFFF_FFFC, 1, 0, 0, 32'h10,
            mk_exp(1, 1, 32'h4, 1, 0, 0, 8'h01, 32'hFFFF_FFFC, 32'h10), 0, 0));
        // desync on non-branch
        vecs.push_back(mk(32'h130, 0, 8'h07, 32'h0, 1, 32'h140, 0, 0, 0, 32'h0,
            mk_exp(1, 1, 32'h144, 0, 0, 0, 8'h00, 32'h0, 32'h0), 0, 0));
        // desync on taken branch
        vecs.push_back(mk(32'h130, 0, 8'h07, 32'h0, 1, 32'h150, 1, 0, 1, 32'h800,
            mk_exp(1, 1, 32'h800, 0, 0, 0, 8'h00, 32'h0, 32'h0), 0, 0));
        // correct non-branch: no outputs at all
        vecs.push_back(mk(32'h140, 0, 8'h09, 32'h0, 1, 32'h140, 0, 0, 0, 32'h0,
            mk_exp(0, 0, 0, 0, 0, 0, 8'h00, 32'h0, 32'h0), 1, 1));

        do_reset();
        check("reset pred_ready", bus.pred_ready, 1);
        check("reset res_ready", bus.res_ready, 0);

        foreach (vecs[i]) begin
            do_reset();
            set_push(vecs[i].p_pc, vecs[i].p_tk, vecs[i].p_idx, vecs[i].p_tgt);
            @(negedge clk);
            clear();
            if (vecs[i].two) begin
                set_push(vecs[i].p_pc + 32'd4, 0, 8'h00, 32'h0);
                @(negedge clk);
                clear();
            end
            check($sformatf("vec%0d res_ready before", i), bus.res_ready, 1);
            set_res(vecs[i].r_pc, vecs[i].r_br, vecs[i].r_jmp, vecs[i].r_tk, vecs[i].r_tgt);
            exp_q.push_back(vecs[i].e);
            @(negedge clk);
            clear();
            check($sformatf("vec%0d res_ready +1", i), bus.res_ready, vecs[i].rdy1);
            @(negedge clk);
            check($sformatf("vec%0d res_ready +2", i), bus.res_ready, vecs[i].rdy2);
        end

        // Fill to DEPTH, overflow push dropped, then pop+push keeps count.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            set_push(32'h100 + 32'(4 * k), 0, 8'(8'h10 + k), 32'h0);
            @(negedge clk);
        end
        clear();
        check("full pred_ready", bus.pred_ready, 0);
        set_push(32'hBAD0, 1, 8'hEE, 32'hBAD0);
        @(negedge clk);
        clear();
        check("full still", bus.pred_ready, 0);
        set_res(32'h100, 1, 0, 0, 32'h0);
        exp_q.push_back(mk_exp(0, 0, 0, 1, 0, 0, 8'h10, 32'h100, 32'h0));
        @(negedge clk);
        clear();
        check("after pop pred_ready", bus.pred_ready, 1);
        set_res(32'h104, 1, 0, 0, 32'h0);
        set_push(32'h110, 0, 8'h14, 32'h0);
        exp_q.push_back(mk_exp(0, 0, 0, 1, 0, 0, 8'h11, 32'h104, 32'h0));
        @(negedge clk);
        clear();
        check("pop+push pred_ready", bus.pred_ready, 1);
        set_push(32'h114, 0, 8'h15, 32'h0);
        @(negedge clk);
        clear();
        check("refull pred_ready", bus.pred_ready, 0);
        for (int k = 2; k < 6; k++) begin
            set_res(32'h100 + 32'(4 * k), 1, 0, 0, 32'h0);
            exp_q.push_back(mk_exp(0, 0, 0, 1, 0, 0, 8'(8'h10 + k), 32'h100 + 32'(4 * k), 32'h0));
            @(negedge clk);
        end
        clear();
        check("drained res_ready", bus.res_ready, 0);

        // Exception flush beats a same-cycle pop and push.
        do_reset();
        set_push(32'h100, 1, 8'h3A, 32'h200);
        @(negedge clk);
        set_push(32'h104, 0, 8'h00, 32'h0);
        @(negedge clk);
        clear();
        set_res(32'h100, 1, 0, 1, 32'h200);
        set_push(32'h108, 0, 8'h00, 32'h0);
        bus.exc_flush = 1;
        bus.exc_pc_in = 32'hBFC0_0380;
        exp_q.push_back(mk_exp(1, 0, 32'hBFC0_0380, 0, 0, 0, 8'h00, 32'h0, 32'h0));
        @(negedge clk);
        clear();
        check("exc res_ready +1", bus.res_ready, 0);
        @(negedge clk);
        check("exc res_ready +2", bus.res_ready, 0);
        check("exc pred_ready", bus.pred_ready, 1);

        // Async reset right after a mispredict clears the redirect and the kept delay slot.
        do_reset();
        set_push(32'h100, 0, 8'h11, 32'h0);
        @(negedge clk);
        set_push(32'h104, 0, 8'h00, 32'h0);
        @(negedge clk);
        clear();
        set_res(32'h100, 1, 0, 1, 32'h300);
        exp_q.push_back(mk_exp(1, 1, 32'h300, 1, 0, 1, 8'h11, 32'h100, 32'h300));
        @(posedge clk);
        #3;
        rst = 0;
        #1;
        check("arst flush_out", bus.flush_out, 0);
        check("arst mispredict_out", bus.mispredict_out, 0);
        check("arst is_branch_out", bus.is_branch_out, 0);
        check("arst res_ready", bus.res_ready, 0);
        check("arst pred_ready", bus.pred_ready, 1);
        @(negedge clk);
        clear();
        rst = 1;
        @(negedge clk);
        check("post-arst res_ready", bus.res_ready, 0);

        @(negedge clk);
        check("expectations consumed", 128'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
